// File: rtl/fetch_prefetch_if.sv
// Instruction-memory request/response bus between the fetch prefetcher
// (master) and an in-order, variable-latency instruction memory (slave).
interface fetch_prefetch_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    logic                     req_valid;
    logic                     req_ready;
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic                     rsp_valid;
    logic [DATA_WIDTH-1:0]    rsp_data;

    modport master (
        output req_valid, req_addr,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/fetch_prefetch.sv
// Prefetching fetch stage: issues sequential fetch requests against a
// credit budget, queues in-order responses with their PCs, presents the
// queue head to decode, and flushes on an execute redirect while
// discarding responses that were already in flight.
module fetch_prefetch #(
    parameter int                         DATA_WIDTH    = 32,
    parameter int                         ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_VECTOR  = '0,
    parameter int                         FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_d,
    input  logic                     pc_src_e,
    input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
    fetch_prefetch_if.master         imem,
    output logic                     valid_f,
    output logic [DATA_WIDTH-1:0]    instr_f,
    output logic [ADDRESS_WIDTH-1:0] pc_f,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_f
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;     // counters reach FIFO_DEPTH inclusive
    localparam int SW = CW + 1;     // headroom for the three-way credit sum

    typedef logic [CW-1:0] cnt_t;
    typedef logic [SW-1:0] sum_t;

    localparam logic [ADDRESS_WIDTH-1:0] STEP      = ADDRESS_WIDTH'(4);
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MSK = ~ADDRESS_WIDTH'(3);
    localparam sum_t                     DEPTH_S   = sum_t'(FIFO_DEPTH);

    logic [ADDRESS_WIDTH-1:0] fetch_pc;
    logic [ADDRESS_WIDTH-1:0] resp_pc;
    cnt_t                     occ;
    cnt_t                     outst;
    cnt_t                     drop_cnt;
    logic [PW-1:0]            rd_ptr;
    logic [PW-1:0]            wr_ptr;

    logic [DATA_WIDTH-1:0]    q_instr [FIFO_DEPTH];
    logic [ADDRESS_WIDTH-1:0] q_pc    [FIFO_DEPTH];

    logic                     req_ok;
    logic                     req_fire;
    logic                     rsp_drop;
    logic                     rsp_push;
    logic                     pop;
    sum_t                     credits_used;
    cnt_t                     redir_drop;
    logic [ADDRESS_WIDTH-1:0] redir_pc;

    // Credit accounting and per-cycle handshake decode.
    always_comb begin
        credits_used = sum_t'(occ) + sum_t'(outst) + sum_t'(drop_cnt);
        // Queue entries, in-flight requests and pending discards all hold a
        // credit, so an accepted request always has a queue slot waiting.
        req_ok   = !rst && !pc_src_e && (credits_used < DEPTH_S);
        req_fire = req_ok && imem.req_ready;
        rsp_drop = imem.rsp_valid && (drop_cnt != '0);
        rsp_push = imem.rsp_valid && (drop_cnt == '0) && (outst != '0);
        pop      = valid_f && !stall_d;
        // Every in-flight request becomes a discard; a response landing in
        // the redirect cycle itself retires one of them immediately.
        redir_drop = drop_cnt + outst - cnt_t'(rsp_drop || rsp_push);
        redir_pc   = pc_target_e & ALIGN_MSK;
    end

    assign imem.req_valid = req_ok;
    assign imem.req_addr  = fetch_pc;

    // Control state: reset, then redirect flush, then normal issue/fill/drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_VECTOR;
            resp_pc  <= RESET_VECTOR;
            occ      <= '0;
            outst    <= '0;
            drop_cnt <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (pc_src_e) begin
            fetch_pc <= redir_pc;
            resp_pc  <= redir_pc;
            occ      <= '0;
            outst    <= '0;
            drop_cnt <= redir_drop;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + STEP;
            if (rsp_push) begin
                resp_pc <= resp_pc + STEP;
                wr_ptr  <= wr_ptr + PW'(1);
            end
            if (rsp_drop) drop_cnt <= drop_cnt - cnt_t'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            outst <= outst + cnt_t'(req_fire) - cnt_t'(rsp_push);
            occ   <= occ + cnt_t'(rsp_push) - cnt_t'(pop);
        end
    end

    // Queue storage; payload needs no reset since occ guards its validity.
    always_ff @(posedge clk) begin
        if (!rst && !pc_src_e && rsp_push) begin
            q_instr[wr_ptr] <= imem.rsp_data;
            q_pc[wr_ptr]    <= resp_pc;
        end
    end

    // First-word fall-through head presentation.
    always_comb begin
        valid_f    = (occ != '0);
        instr_f    = q_instr[rd_ptr];
        pc_f       = q_pc[rd_ptr];
        pc_plus4_f = q_pc[rd_ptr] + STEP;
    end
endmodule
